// File: rtl/instr_mem_pipe_if.sv
// Fetch/load bus between the IF stage (master) and the instruction memory (slave).
// Groups the fetch handshake, registered read return and boot-time program-load port.
interface instr_mem_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              flush;
    logic              fetch_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              misalign;
    logic              fault;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_done;

    modport master (
        output fetch_req, fetch_addr, stall, flush,
        output load_we, load_addr, load_data, load_done,
        input  fetch_ready, rd_valid, rd_data, misalign, fault
    );

    modport slave (
        input  fetch_req, fetch_addr, stall, flush,
        input  load_we, load_addr, load_data, load_done,
        output fetch_ready, rd_valid, rd_data, misalign, fault
    );
endinterface

// File: rtl/instr_mem_pipe.sv
// Synchronous-read instruction memory for the IF stage: 1-cycle registered fetch, stall/flush, boot program load.
// Optional macro INSTR_MEM_BOUNDS_CHECK_EN: out-of-range fetches return NOP with fault=1, out-of-range loads are dropped.
module instr_mem_pipe #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter bit                LOAD_BOOT = 1'b1,
    parameter logic [DATA_W-1:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    instr_mem_pipe_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_rd_q;

    logic rd_valid_q, rd_valid_d;
    logic sel_mem_q,  sel_mem_d;
    logic misalign_q, misalign_d;
    logic fault_q,    fault_d;

    logic             fetch_ready;
    logic             accept;
    logic             fetch_mis;
    logic             fetch_oob;
    logic             load_ok;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] load_idx;

    assign fetch_idx = bus.fetch_addr[IDX_W+1:2];
    assign load_idx  = bus.load_addr[IDX_W+1:2];
    assign fetch_mis = (bus.fetch_addr[1:0] != 2'b00);

`ifdef INSTR_MEM_BOUNDS_CHECK_EN
    assign fetch_oob = ((bus.fetch_addr >> (IDX_W + 2)) != '0);
    assign load_ok   = ((bus.load_addr  >> (IDX_W + 2)) == '0);
    assign bus.fault = fault_q;
`else
    // Upper address bits wrap, so they are deliberately left unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.fetch_addr[ADDR_W-1:IDX_W+2],
                                bus.load_addr[ADDR_W-1:IDX_W+2],
                                bus.load_addr[1:0], fault_q};
    assign fetch_oob = 1'b0;
    assign load_ok   = 1'b1;
    assign bus.fault = 1'b0;
`endif

    assign accept = bus.fetch_req && fetch_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD_BOOT ? ST_LOAD : ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_ready = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (bus.load_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fetch_ready = !bus.stall || bus.flush;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Return-path control: accept loads new flags, stall holds, anything else clears to NOP.
    always_comb begin
        rd_valid_d = rd_valid_q;
        sel_mem_d  = sel_mem_q;
        misalign_d = misalign_q;
        fault_d    = fault_q;
        if (accept) begin
            rd_valid_d = 1'b1;
            misalign_d = fetch_mis;
            fault_d    = fetch_oob;
            sel_mem_d  = !fetch_mis && !fetch_oob;
        end else if (bus.flush || !bus.stall) begin
            rd_valid_d = 1'b0;
            misalign_d = 1'b0;
            fault_d    = 1'b0;
            sel_mem_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            sel_mem_q  <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            sel_mem_q  <= sel_mem_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    // Array and read register carry no reset; the old word is sampled before the write lands (read-first).
    always_ff @(posedge clk) begin
        if (bus.load_we && load_ok) begin
            mem_q[load_idx] <= bus.load_data;
        end
        if (accept && !fetch_mis && !fetch_oob) begin
            mem_rd_q <= mem_q[fetch_idx];
        end
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.misalign    = misalign_q;
    assign bus.rd_data     = sel_mem_q ? mem_rd_q : NOP_WORD;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe: boot load, gating, stall, flush, misalign, read-first, bounds and reset.
module tb_instr_mem_pipe;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    instr_mem_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_mem_pipe #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LOAD_BOOT(1'b1), .NOP_WORD(NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.fetch_req = 0; bus.fetch_addr = 0; bus.stall = 0; bus.flush = 0;
        bus.load_we = 0; bus.load_addr = 0; bus.load_data = 0; bus.load_done = 0;
        #3;
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); else passed++;
        total++; if (bus.rd_data !== NOP) $display("FAIL reset_rd_data: got 0x%08h expected 0x%08h", bus.rd_data, NOP); else passed++;
        total++; if (bus.misalign !== 1'b0) $display("FAIL reset_misalign: got %b expected 0", bus.misalign); else passed++;
        total++; if (bus.fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", bus.fault); else passed++;
        step();
        #2 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_gating();
        bus.fetch_req = 1; bus.fetch_addr = 32'h0;
        #1;
        total++; if (bus.fetch_ready !== 1'b0) $display("FAIL gate_ready: got %b expected 0", bus.fetch_ready); else passed++;
        step();
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL gate_rd_valid: got %b expected 0", bus.rd_valid); else passed++;
        bus.fetch_req = 0;
    endtask

    task automatic test_boot_load();
        logic [31:0] words [5];
        words = '{32'h00100A93, 32'h028AAB83, 32'h11111111, 32'h22222222, 32'h33333333};
        for (int i = 0; i < 5; i++) begin
            bus.load_we = 1; bus.load_addr = 32'(i * 4); bus.load_data = words[i];
            bus.load_done = (i == 4);
            step();
        end
        bus.load_we = 0; bus.load_done = 0;
        bus.fetch_req = 1; bus.fetch_addr = 32'h0;
        #1;
        total++; if (bus.fetch_ready !== 1'b1) $display("FAIL run_ready: got %b expected 1", bus.fetch_ready); else passed++;
        step();
        total++; if (bus.rd_valid !== 1'b1) $display("FAIL boot_valid0: got %b expected 1", bus.rd_valid); else passed++;
        total++; if (bus.rd_data !== 32'h00100A93) $display("FAIL boot_data0: got 0x%08h expected 0x00100a93", bus.rd_data); else passed++;
        bus.fetch_addr = 32'h4;
        step();
        total++; if (bus.rd_data !== 32'h028AAB83) $display("FAIL boot_data4: got 0x%08h expected 0x028aab83", bus.rd_data); else passed++;
    endtask

    task automatic test_stall();
        bus.fetch_req = 1; bus.fetch_addr = 32'h8;
        step();
        total++; if (bus.rd_data !== 32'h11111111) $display("FAIL stall_first: got 0x%08h expected 0x11111111", bus.rd_data); else passed++;
        bus.stall = 1; bus.fetch_addr = 32'hC;
        #1;
        total++; if (bus.fetch_ready !== 1'b0) $display("FAIL stall_ready: got %b expected 0", bus.fetch_ready); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.rd_data !== 32'h11111111 || bus.rd_valid !== 1'b1)
                $display("FAIL stall_hold%0d: got 0x%08h/%b expected 0x11111111/1", i, bus.rd_data, bus.rd_valid); else passed++;
        end
        bus.stall = 0;
        step();
        total++; if (bus.rd_data !== 32'h22222222) $display("FAIL stall_release: got 0x%08h expected 0x22222222", bus.rd_data); else passed++;
    endtask

    task automatic test_flush();
        bus.fetch_req = 0; bus.flush = 1;
        step();
        total++; if (bus.rd_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", bus.rd_valid); else passed++;
        total++; if (bus.rd_data !== NOP) $display("FAIL flush_data: got 0x%08h expected 0x00000013", bus.rd_data); else passed++;
        bus.stall = 1; bus.fetch_req = 1; bus.fetch_addr = 32'h10;
        #1;
        total++; if (bus.fetch_ready !== 1'b1) $display("FAIL flush_ready: got %b expected 1", bus.fetch_ready); else passed++;
        step();
        total++; if (bus.rd_data !== 32'h33333333 || bus.rd_valid !== 1'b1)
            $display("FAIL flush_redirect: got 0x%08h/%b expected 0x33333333/1", bus.rd_data, bus.rd_valid); else passed++;
        bus.flush = 0; bus.stall = 0;
    endtask

    task automatic test_idle();
        bus.fetch_req = 0;
        step();
        total++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== NOP)
            $display("FAIL idle: got 0x%08h/%b expected 0x00000013/0", bus.rd_data, bus.rd_valid); else passed++;
    endtask

    task automatic test_misalign();
        bus.fetch_req = 1; bus.fetch_addr = 32'h6;
        step();
        total++; if (bus.rd_data !== NOP) $display("FAIL mis_data: got 0x%08h expected 0x00000013", bus.rd_data); else passed++;
        total++; if (bus.misalign !== 1'b1 || bus.rd_valid !== 1'b1)
            $display("FAIL mis_flags: got misalign=%b valid=%b expected 1/1", bus.misalign, bus.rd_valid); else passed++;
        bus.fetch_addr = 32'h4;
        step();
        total++; if (bus.misalign !== 1'b0) $display("FAIL mis_clear: got %b expected 0", bus.misalign); else passed++;
    endtask

    task automatic test_read_first();
        bus.fetch_req = 1; bus.fetch_addr = 32'h4;
        bus.load_we = 1; bus.load_addr = 32'h4; bus.load_data = 32'hDEADBEEF;
        step();
        bus.load_we = 0;
        total++; if (bus.rd_data !== 32'h028AAB83) $display("FAIL rf_old: got 0x%08h expected 0x028aab83", bus.rd_data); else passed++;
        step();
        total++; if (bus.rd_data !== 32'hDEADBEEF) $display("FAIL rf_new: got 0x%08h expected 0xdeadbeef", bus.rd_data); else passed++;
    endtask

    task automatic test_bounds();
        logic [31:0] exp_data;
        logic        exp_fault;
        logic [31:0] exp_wrap;
`ifdef INSTR_MEM_BOUNDS_CHECK_EN
        exp_data = NOP;          exp_fault = 1'b1; exp_wrap = 32'h11111111;
`else
        exp_data = 32'h00100A93; exp_fault = 1'b0; exp_wrap = 32'h55555555;
`endif
        bus.fetch_req = 1; bus.fetch_addr = 32'h1000;
        step();
        total++; if (bus.rd_data !== exp_data) $display("FAIL oob_data: got 0x%08h expected 0x%08h", bus.rd_data, exp_data); else passed++;
        total++; if (bus.fault !== exp_fault || bus.rd_valid !== 1'b1)
            $display("FAIL oob_fault: got fault=%b valid=%b expected %b/1", bus.fault, bus.rd_valid, exp_fault); else passed++;
        bus.fetch_req = 0;
        bus.load_we = 1; bus.load_addr = 32'h1008; bus.load_data = 32'h55555555;
        step();
        bus.load_we = 0;
        bus.fetch_req = 1; bus.fetch_addr = 32'h8;
        step();
        total++; if (bus.rd_data !== exp_wrap) $display("FAIL oob_load: got 0x%08h expected 0x%08h", bus.rd_data, exp_wrap); else passed++;
        total++; if (bus.fault !== 1'b0) $display("FAIL oob_fault_clear: got %b expected 0", bus.fault); else passed++;
    endtask

    task automatic test_reset_midfetch();
        bus.fetch_req = 1; bus.fetch_addr = 32'h0;
        step();
        bus.fetch_addr = 32'h10;
        #2 rst = 1'b0;
        #1;
        total++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== NOP)
            $display("FAIL async_reset: got 0x%08h/%b expected 0x00000013/0", bus.rd_data, bus.rd_valid); else passed++;
        #3 rst = 1'b1;
        #1;
        total++; if (bus.fetch_ready !== 1'b0) $display("FAIL reboot_load: got %b expected 0", bus.fetch_ready); else passed++;
        @(posedge clk); #1;
        bus.load_done = 1; bus.fetch_addr = 32'h0;
        step();
        bus.load_done = 0;
        step();
        total++; if (bus.rd_data !== 32'h00100A93) $display("FAIL mem_kept: got 0x%08h expected 0x00100a93", bus.rd_data); else passed++;
        bus.fetch_req = 0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_load_gating();
        test_boot_load();
        test_stall();
        test_flush();
        test_idle();
        test_misalign();
        test_read_first();
        test_bounds();
        test_reset_midfetch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
